// File: rtl/program_loader.sv
// Boot-time loader: packs a big-endian byte stream into 32-bit words, writes them to
// instruction RAM from address 0, then releases the core once the terminator word arrives.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] END_WORD   = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  imem_write_en,
    output logic [ADDR_WIDTH-1:0] imem_write_addr,
    output logic [31:0]           imem_write_data,
    output logic                  cpu_hold,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [ADDR_WIDTH:0] WORD_LIMIT = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t      state;
    logic [1:0]  byte_idx;
    logic [23:0] partial;
    logic        accept;
    logic [31:0] next_word;

    always_comb begin
        accept    = (state == S_LOAD) && byte_valid && byte_ready;
        next_word = {partial, byte_in};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            byte_idx        <= '0;
            partial         <= '0;
            byte_ready      <= 1'b0;
            imem_write_en   <= 1'b0;
            imem_write_addr <= '0;
            imem_write_data <= '0;
            cpu_hold        <= 1'b1;
            cpu_reset       <= 1'b1;
            load_done       <= 1'b0;
            load_error      <= 1'b0;
            word_count      <= '0;
        end else begin
            imem_write_en <= 1'b0;
            case (state)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (start) begin
                        state      <= S_LOAD;
                        byte_idx   <= '0;
                        word_count <= '0;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                        cpu_hold   <= 1'b1;
                        cpu_reset  <= 1'b1;
                        byte_ready <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        partial  <= {partial[15:0], byte_in};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            byte_ready <= 1'b0;
                            // Terminator takes priority over the overflow test so a
                            // full-depth image still boots.
                            if (next_word == END_WORD) begin
                                state    <= S_RELEASE;
                                cpu_hold <= 1'b0;
                            end else if (word_count == WORD_LIMIT) begin
                                state      <= S_ERROR;
                                load_error <= 1'b1;
                            end else begin
                                state           <= S_WRITE;
                                imem_write_en   <= 1'b1;
                                imem_write_addr <= word_count[ADDR_WIDTH-1:0];
                                imem_write_data <= next_word;
                            end
                        end
                    end
                end

                S_WRITE: begin
                    state      <= S_LOAD;
                    byte_ready <= 1'b1;
                    if (word_count != WORD_LIMIT) begin
                        word_count <= word_count + 1'b1;
                    end
                end

                S_RELEASE: begin
                    state     <= S_RUN;
                    cpu_reset <= 1'b0;
                    load_done <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: full-depth instance plus a 4-word instance for overflow.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;

    logic        byte_ready, imem_write_en, cpu_hold, cpu_reset, load_done, load_error;
    logic [7:0]  imem_write_addr;
    logic [31:0] imem_write_data;
    logic [8:0]  word_count;

    logic        s_byte_ready, s_imem_write_en, s_cpu_hold, s_cpu_reset, s_load_done, s_load_error;
    logic [1:0]  s_imem_write_addr;
    logic [31:0] s_imem_write_data;
    logic [2:0]  s_word_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] ram [0:255];
    logic [31:0] sram [0:3];
    int wr_count, swr_count, dbl_strobe;
    logic prev_we = 1'b0;

    program_loader #(.ADDR_WIDTH(8), .END_WORD(32'hFFFF_FFFF)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .imem_write_en(imem_write_en), .imem_write_addr(imem_write_addr),
        .imem_write_data(imem_write_data), .cpu_hold(cpu_hold), .cpu_reset(cpu_reset),
        .load_done(load_done), .load_error(load_error), .word_count(word_count)
    );

    program_loader #(.ADDR_WIDTH(2), .END_WORD(32'hFFFF_FFFF)) dut_small (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(s_byte_ready), .imem_write_en(s_imem_write_en),
        .imem_write_addr(s_imem_write_addr), .imem_write_data(s_imem_write_data),
        .cpu_hold(s_cpu_hold), .cpu_reset(s_cpu_reset), .load_done(s_load_done),
        .load_error(s_load_error), .word_count(s_word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record RAM writes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (imem_write_en) begin
            ram[imem_write_addr] = imem_write_data;
            wr_count++;
            if (prev_we) dbl_strobe++;
        end
        prev_we = imem_write_en;
        if (s_imem_write_en) begin
            sram[s_imem_write_addr] = s_imem_write_data;
            swr_count++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic clear_mon();
        for (int i = 0; i < 256; i++) ram[i] = '0;
        for (int i = 0; i < 4; i++) sram[i] = '0;
        wr_count = 0;
        swr_count = 0;
        dbl_strobe = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and wait until it is taken; sel picks which instance's ready to follow.
    task automatic send_byte(input logic [7:0] b, input bit sel);
        bit rdy;
        int n;
        byte_in = b;
        byte_valid = 1'b1;
        n = 0;
        do begin
            rdy = sel ? s_byte_ready : byte_ready;
            tick();
            n++;
        end while (!rdy && n < 20);
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL handshake_timeout byte %0h not accepted within %0d cycles", b, n);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        byte_valid = 1'b1;
        byte_in = 8'hAA;
        repeat (3) tick();
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL rst_byte_ready got %0b exp 0", byte_ready); end
        checks++; if (imem_write_en !== 1'b0) begin errors++; $display("FAIL rst_write_en got %0b exp 0", imem_write_en); end
        checks++; if (imem_write_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %0h exp 0", imem_write_addr); end
        checks++; if (imem_write_data !== 32'h0) begin errors++; $display("FAIL rst_data got %0h exp 0", imem_write_data); end
        checks++; if (cpu_hold !== 1'b1 || cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu hold=%0b reset=%0b exp 1 1", cpu_hold, cpu_reset); end
        checks++; if (load_done !== 1'b0 || load_error !== 1'b0) begin errors++; $display("FAIL rst_flags done=%0b err=%0b exp 0 0", load_done, load_error); end
        checks++; if (word_count !== 9'd0) begin errors++; $display("FAIL rst_word_count got %0d exp 0", word_count); end
        reset = 1'b0;
        clear_mon();
        repeat (2) tick();
        checks++; if (byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL idle_after_rst ready=%0b hold=%0b exp 0 1", byte_ready, cpu_hold); end
        checks++; if (wr_count !== 0) begin errors++; $display("FAIL idle_no_write got %0d exp 0", wr_count); end
        byte_valid = 1'b0;
    endtask

    task automatic test_basic_load();
        logic [7:0] img [12] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07,
                                 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        int e;
        clear_mon();
        // first byte already valid alongside start: IDLE must not take it
        byte_in = img[0];
        byte_valid = 1'b1;
        do_start();
        e = cyc;
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after_start got %0b exp 1", byte_ready); end
        for (int i = 0; i < 12; i++) begin
            send_byte(img[i], 1'b0);
            if (i == 3) begin
                checks++; if (imem_write_en !== 1'b1 || imem_write_addr !== 8'd0 || imem_write_data !== 32'h2008_0005) begin
                    errors++; $display("FAIL basic_write0 en=%0b addr=%0h data=%0h exp 1 0 20080005", imem_write_en, imem_write_addr, imem_write_data); end
                checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_write got %0b exp 0", byte_ready); end
            end
        end
        byte_valid = 1'b0;
        checks++; if (cyc - e !== 14) begin errors++; $display("FAIL basic_cycles got %0d exp 14", cyc - e); end
        checks++; if (cpu_hold !== 1'b0 || cpu_reset !== 1'b1 || load_done !== 1'b0) begin
            errors++; $display("FAIL basic_release hold=%0b reset=%0b done=%0b exp 0 1 0", cpu_hold, cpu_reset, load_done); end
        checks++; if (imem_write_en !== 1'b0) begin errors++; $display("FAIL basic_term_not_written en=%0b exp 0", imem_write_en); end
        tick();
        checks++; if (cpu_hold !== 1'b0 || cpu_reset !== 1'b0 || load_done !== 1'b1) begin
            errors++; $display("FAIL basic_run hold=%0b reset=%0b done=%0b exp 0 0 1", cpu_hold, cpu_reset, load_done); end
        checks++; if (word_count !== 9'd2) begin errors++; $display("FAIL basic_word_count got %0d exp 2", word_count); end
        checks++; if (wr_count !== 2 || dbl_strobe !== 0) begin errors++; $display("FAIL basic_strobes writes=%0d doubles=%0d exp 2 0", wr_count, dbl_strobe); end
        checks++; if (ram[0] !== 32'h2008_0005 || ram[1] !== 32'h2009_0007 || ram[2] !== 32'h0) begin
            errors++; $display("FAIL basic_ram r0=%0h r1=%0h r2=%0h exp 20080005 20090007 0", ram[0], ram[1], ram[2]); end
        tick();
        checks++; if (byte_ready !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL run_ignores ready=%0b done=%0b exp 0 1", byte_ready, load_done); end
    endtask

    task automatic test_reload();
        logic [7:0] img [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        clear_mon();
        do_start();
        checks++; if (cpu_hold !== 1'b1 || cpu_reset !== 1'b1 || load_done !== 1'b0) begin
            errors++; $display("FAIL reload_enter hold=%0b reset=%0b done=%0b exp 1 1 0", cpu_hold, cpu_reset, load_done); end
        checks++; if (word_count !== 9'd0 || byte_ready !== 1'b1) begin errors++; $display("FAIL reload_clear wc=%0d ready=%0b exp 0 1", word_count, byte_ready); end
        for (int i = 0; i < 8; i++) send_byte(img[i], 1'b0);
        byte_valid = 1'b0;
        tick();
        checks++; if (ram[0] !== 32'h1122_3344 || wr_count !== 1) begin errors++; $display("FAIL reload_ram r0=%0h writes=%0d exp 11223344 1", ram[0], wr_count); end
        checks++; if (load_done !== 1'b1 || word_count !== 9'd1) begin errors++; $display("FAIL reload_done done=%0b wc=%0d exp 1 1", load_done, word_count); end
    endtask

    task automatic test_stalls();
        logic [7:0] img [12] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07,
                                 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        int gaps [12] = '{0, 1, 2, 0, 0, 1, 3, 1, 0, 2, 1, 1};
        clear_mon();
        do_start();
        for (int i = 0; i < 12; i++) begin
            if (gaps[i] != 0) begin
                byte_valid = 1'b0;
                byte_in = 8'hEE;
                repeat (gaps[i]) tick();
            end
            send_byte(img[i], 1'b0);
        end
        byte_valid = 1'b0;
        tick();
        checks++; if (ram[0] !== 32'h2008_0005 || ram[1] !== 32'h2009_0007) begin
            errors++; $display("FAIL stall_ram r0=%0h r1=%0h exp 20080005 20090007", ram[0], ram[1]); end
        checks++; if (wr_count !== 2 || word_count !== 9'd2 || load_done !== 1'b1) begin
            errors++; $display("FAIL stall_done writes=%0d wc=%0d done=%0b exp 2 2 1", wr_count, word_count, load_done); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] img [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] pre [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55, 8'h66};
        do_start();
        for (int i = 0; i < 6; i++) send_byte(pre[i], 1'b0);
        reset = 1'b1;
        #1;
        checks++; if (byte_ready !== 1'b0 || imem_write_en !== 1'b0 || word_count !== 9'd0) begin
            errors++; $display("FAIL midrst_async ready=%0b en=%0b wc=%0d exp 0 0 0", byte_ready, imem_write_en, word_count); end
        checks++; if (cpu_hold !== 1'b1 || cpu_reset !== 1'b1 || imem_write_addr !== 8'd0 || imem_write_data !== 32'h0) begin
            errors++; $display("FAIL midrst_outs hold=%0b reset=%0b addr=%0h data=%0h exp 1 1 0 0", cpu_hold, cpu_reset, imem_write_addr, imem_write_data); end
        byte_valid = 1'b0;
        tick();
        reset = 1'b0;
        clear_mon();
        tick();
        do_start();
        for (int i = 0; i < 8; i++) send_byte(img[i], 1'b0);
        byte_valid = 1'b0;
        tick();
        checks++; if (ram[0] !== 32'h0102_0304 || wr_count !== 1 || load_done !== 1'b1) begin
            errors++; $display("FAIL midrst_reload r0=%0h writes=%0d done=%0b exp 01020304 1 1", ram[0], wr_count, load_done); end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_mon();
        tick();
        do_start();
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                b = (j == 0) ? 8'(8'h10 + k) : (j == 3) ? 8'(8'h40 + k) : 8'(8'h20 + 8'(j));
                send_byte(b, 1'b1);
            end
        end
        byte_valid = 1'b0;
        checks++; if (s_load_error !== 1'b1 || s_imem_write_en !== 1'b0) begin
            errors++; $display("FAIL ovf_error err=%0b en=%0b exp 1 0", s_load_error, s_imem_write_en); end
        checks++; if (s_cpu_hold !== 1'b1 || s_cpu_reset !== 1'b1 || s_byte_ready !== 1'b0 || s_load_done !== 1'b0) begin
            errors++; $display("FAIL ovf_cpu hold=%0b reset=%0b ready=%0b done=%0b exp 1 1 0 0", s_cpu_hold, s_cpu_reset, s_byte_ready, s_load_done); end
        tick();
        checks++; if (swr_count !== 4 || s_word_count !== 3'd4) begin errors++; $display("FAIL ovf_count writes=%0d wc=%0d exp 4 4", swr_count, s_word_count); end
        checks++; if (sram[0] !== 32'h1021_2240 || sram[1] !== 32'h1121_2241 || sram[2] !== 32'h1221_2242 || sram[3] !== 32'h1321_2243) begin
            errors++; $display("FAIL ovf_ram %0h %0h %0h %0h exp 10212240 11212241 12212242 13212243", sram[0], sram[1], sram[2], sram[3]); end
        checks++; if (s_load_error !== 1'b1) begin errors++; $display("FAIL ovf_error_held got %0b exp 1", s_load_error); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic_load();
        test_reload();
        test_stalls();
        test_reset_mid();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
